// File: rtl/sa_operand_feeder.sv
// sa_operand_feeder
// Buffers one N x N operand pair (A delivered one column per beat, B one row
// per beat) and streams it into the west (A rows) and north (B columns) edges
// of an N x N systolic multiply array. Row i / column j is delayed by i / j
// cycles so operands meet at the right PE; lanes outside the valid diagonal
// window carry 0. After streaming, FLUSH_CYC zero cycles let the grid drain,
// then done pulses for one cycle.
//
// Build option: define SA_FEEDER_DOUBLE_BUF_EN for an active/shadow buffer
// pair. The next matrix pair then loads while the current one streams, and a
// full shadow buffer starts streaming directly out of FLUSH with no IDLE gap.

module sa_operand_feeder #(
    parameter int N         = 4,
    parameter int DW        = 4,
    parameter int FLUSH_CYC = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [N*DW-1:0] ld_a,
    input  logic [N*DW-1:0] ld_b,
    output logic [N*DW-1:0] a_edge,
    output logic [N*DW-1:0] b_edge,
    output logic            edge_valid,
    output logic            busy,
    output logic            done
);

    localparam int KW   = (N > 1) ? $clog2(N) : 1;
    localparam int TMAX = (2 * N - 1 > FLUSH_CYC) ? 2 * N - 1 : FLUSH_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [KW-1:0] K_LAST        = KW'(N - 1);
    localparam logic [TW-1:0] T_STREAM_LAST = TW'(2 * N - 2);
    localparam logic [TW-1:0] T_FLUSH_LAST  = TW'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t          st_q, st_d;
    logic [KW-1:0]   k_q, k_d;
    logic [TW-1:0]   t_q, t_d;
    logic [N*DW-1:0] a_edge_q, a_edge_d;
    logic [N*DW-1:0] b_edge_q, b_edge_d;
    logic            edge_valid_q, edge_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            ld_fire;
    logic            last_beat;
    logic            start_stream;

`ifdef SA_FEEDER_DOUBLE_BUF_EN
    // Bank act_q streams, bank ~act_q loads; full_q marks N unconsumed beats.
    logic [N*DW-1:0] a_mem [2][N];
    logic [N*DW-1:0] b_mem [2][N];
    logic            act_q, act_d;
    logic            full_q, full_d;
`else
    logic [N*DW-1:0] a_mem [N];
    logic [N*DW-1:0] b_mem [N];
`endif

    // Buffer slots the next edge-register value is read from.
    logic [N*DW-1:0] rd_a [N];
    logic [N*DW-1:0] rd_b [N];

    // Handshake: ready depends only on registered state, never on ld_valid.
`ifdef SA_FEEDER_DOUBLE_BUF_EN
    assign ld_ready = !full_q;
`else
    assign ld_ready = (st_q == IDLE) || (st_q == LOAD);
`endif
    assign ld_fire   = ld_valid && ld_ready;
    assign last_beat = ld_fire && (k_q == K_LAST);

    // Beat capture: beat k lands in slot k of the load-side buffer.
    // NOTE: operand storage has no reset; the state and k counter decide what
    // is read, so stale contents after reset are never observed.
    always_ff @(posedge clk) begin
        if (ld_fire) begin
`ifdef SA_FEEDER_DOUBLE_BUF_EN
            a_mem[~act_q][k_q] <= ld_a;
            b_mem[~act_q][k_q] <= ld_b;
`else
            a_mem[k_q] <= ld_a;
            b_mem[k_q] <= ld_b;
`endif
        end
    end

    // Select the buffer that will be active in the next cycle.
    always_comb begin
        for (int k = 0; k < N; k++) begin
`ifdef SA_FEEDER_DOUBLE_BUF_EN
            rd_a[k] = a_mem[act_d][k];
            rd_b[k] = b_mem[act_d][k];
`else
            rd_a[k] = a_mem[k];
            rd_b[k] = b_mem[k];
`endif
        end
    end

    // Next state, beat counter k and stream/flush counter t.
    always_comb begin
        // NOTE: every value written here gets a hold/default first, so no
        // path through the case statement can infer a latch.
        st_d         = st_q;
        k_d          = k_q;
        t_d          = t_q;
        done_d       = 1'b0;
        start_stream = 1'b0;
`ifdef SA_FEEDER_DOUBLE_BUF_EN
        act_d        = act_q;
        full_d       = full_q;
        if (last_beat) begin
            full_d = 1'b1;
        end
`endif
        if (ld_fire) begin
            k_d = last_beat ? '0 : k_q + 1'b1;
        end

        unique case (st_q)
            IDLE: begin
                if (ld_fire) begin
                    if (last_beat) begin
                        start_stream = 1'b1;
                    end else begin
                        st_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (last_beat) begin
                    start_stream = 1'b1;
                end
            end
            STREAM: begin
                if (t_q == T_STREAM_LAST) begin
                    st_d = FLUSH;
                    t_d  = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            FLUSH: begin
                if (t_q == T_FLUSH_LAST) begin
                    done_d = 1'b1;
                    st_d   = IDLE;
                    t_d    = '0;
`ifdef SA_FEEDER_DOUBLE_BUF_EN
                    // A shadow buffer completed by now goes straight to STREAM.
                    if (full_d) begin
                        start_stream = 1'b1;
                    end
`endif
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase

        if (start_stream) begin
            st_d = STREAM;
            t_d  = '0;
`ifdef SA_FEEDER_DOUBLE_BUF_EN
            act_d  = ~act_q;
            full_d = 1'b0;
`endif
        end
    end

    // Skewed edge values for the next cycle: lane i carries slot t-i.
    always_comb begin
        int              idx;
        logic [KW-1:0]   sel;
        idx          = 0;
        sel          = '0;
        a_edge_d     = '0;
        b_edge_d     = '0;
        edge_valid_d = (st_d == STREAM);
        busy_d       = (st_d == STREAM) || (st_d == FLUSH);
        if (st_d == STREAM) begin
            for (int i = 0; i < N; i++) begin
                idx = int'(t_d) - i;
                if (idx >= 0 && idx < N) begin
                    sel = idx[KW-1:0];
                    // Lane i of A column (t-i) is A[i][t-i]; lane j of B row (t-j) is B[t-j][j].
                    a_edge_d[DW*i +: DW] = rd_a[sel][DW*i +: DW];
                    b_edge_d[DW*i +: DW] = rd_b[sel][DW*i +: DW];
                end
            end
        end
    end

    // FSM state, counters and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q         <= IDLE;
            k_q          <= '0;
            t_q          <= '0;
            a_edge_q     <= '0;
            b_edge_q     <= '0;
            edge_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SA_FEEDER_DOUBLE_BUF_EN
            act_q        <= 1'b0;
            full_q       <= 1'b0;
`endif
        end else begin
            st_q         <= st_d;
            k_q          <= k_d;
            t_q          <= t_d;
            a_edge_q     <= a_edge_d;
            b_edge_q     <= b_edge_d;
            edge_valid_q <= edge_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef SA_FEEDER_DOUBLE_BUF_EN
            act_q        <= act_d;
            full_q       <= full_d;
`endif
        end
    end

    assign a_edge     = a_edge_q;
    assign b_edge     = b_edge_q;
    assign edge_valid = edge_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sa_operand_feeder.sv
// Self-checking bench for sa_operand_feeder (default parameters N=4, DW=4,
// FLUSH_CYC=7). Directed matrices are checked against a hand-computed table;
// random matrices and random load gaps are checked against the skew formula
// evaluated directly on the bench's own copy of the matrices.

module tb_sa_operand_feeder;

    localparam int N         = 4;
    localparam int DW        = 4;
    localparam int FLUSH_CYC = 7;
    localparam int W         = N * DW;
    localparam int NT        = 2 * N - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ld_valid = 1'b0;
    logic         ld_ready;
    logic [W-1:0] ld_a = '0;
    logic [W-1:0] ld_b = '0;
    logic [W-1:0] a_edge;
    logic [W-1:0] b_edge;
    logic         edge_valid;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    // Reference copies: ma/mb is the pair expected on the edges, nxa/nxb the next pair.
    logic [DW-1:0] ma  [N][N];
    logic [DW-1:0] mb  [N][N];
    logic [DW-1:0] nxa [N][N];
    logic [DW-1:0] nxb [N][N];
    logic [W-1:0]  seen_a [NT];
    logic [W-1:0]  seen_b [NT];

    typedef struct {
        int           t;
        logic [W-1:0] a_exp;
        logic [W-1:0] b_exp;
    } vec_t;
    vec_t vecs [4];

    sa_operand_feeder #(.N(N), .DW(DW), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_a       (ld_a),
        .ld_b       (ld_b),
        .a_edge     (a_edge),
        .b_edge     (b_edge),
        .edge_valid (edge_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] beat_a(input int k, input bit nxt);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[DW*i +: DW] = nxt ? nxa[i][k] : ma[i][k];
        return v;
    endfunction

    function automatic logic [W-1:0] beat_b(input int k, input bit nxt);
        logic [W-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) v[DW*j +: DW] = nxt ? nxb[k][j] : mb[k][j];
        return v;
    endfunction

    // Edge values at stream step t: lane i = A[i][t-i], lane j = B[t-j][j], 0 outside.
    function automatic logic [W-1:0] exp_a(input int t);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) v[DW*i +: DW] = ma[i][t-i];
        return v;
    endfunction

    function automatic logic [W-1:0] exp_b(input int t);
        logic [W-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) v[DW*j +: DW] = mb[t-j][j];
        return v;
    endfunction

    task automatic set_directed();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                ma[i][k] = DW'(i + k + 1);
                mb[i][k] = DW'(2 * i + k);
            end
    endtask

    task automatic rand_pair(input bit nxt);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                if (nxt) begin
                    nxa[r][c] = DW'($urandom_range(1, 15));
                    nxb[r][c] = DW'($urandom_range(1, 15));
                end else begin
                    ma[r][c] = DW'($urandom_range(1, 15));
                    mb[r][c] = DW'($urandom_range(1, 15));
                end
            end
    endtask

    task automatic promote();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = nxa[r][c];
                mb[r][c] = nxb[r][c];
            end
    endtask

    // Drive beats k0.. following pat (bit c = ld_valid in cycle c); last bit completes the load.
    task automatic load(input logic [31:0] pat, input int len, input int k0);
        int k;
        k = k0;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            check("ld_ready_load", ld_ready, 1);
            ld_valid = pat[c];
            if (pat[c]) begin
                ld_a = beat_a(k, 0);
                ld_b = beat_b(k, 0);
                k++;
            end else begin
                ld_a = W'($urandom);
                ld_b = W'($urandom);
            end
        end
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    // Called at the negedge showing t=0; returns at the negedge after FLUSH.
    task automatic expect_stream(input bit done_t0, input int feed);
        int fed;
        bit in_s;
        fed = 0;
        for (int c = 0; c < NT + FLUSH_CYC; c++) begin
            in_s = (c < NT);
            if (in_s) begin
                seen_a[c] = a_edge;
                seen_b[c] = b_edge;
                check("a_edge_stream", a_edge, exp_a(c));
                check("b_edge_stream", b_edge, exp_b(c));
            end else begin
                check("a_edge_flush", a_edge, 0);
                check("b_edge_flush", b_edge, 0);
            end
            check("edge_valid", edge_valid, in_s);
            check("busy_run", busy, 1);
            check("done_run", done, (c == 0) ? done_t0 : 1'b0);
`ifdef SA_FEEDER_DOUBLE_BUF_EN
            check("ld_ready_shadow", ld_ready, (fed < N) ? 1 : 0);
            if (fed < feed) begin
                ld_valid = 1'b1;
                ld_a = beat_a(fed, 1);
                ld_b = beat_b(fed, 1);
                fed++;
            end else begin
                ld_valid = 1'b0;
            end
`else
            check("ld_ready_run", ld_ready, 0);
            ld_valid = 1'b1;
            ld_a = W'($urandom);
            ld_b = W'($urandom);
`endif
            @(negedge clk);
        end
        ld_valid = 1'b0;
    endtask

    task automatic expect_done_idle();
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("edge_valid_done", edge_valid, 0);
        check("a_edge_done", a_edge, 0);
        check("b_edge_done", b_edge, 0);
        check("ld_ready_done", ld_ready, 1);
        @(negedge clk);
        check("done_once", done, 0);
        check("busy_idle", busy, 0);
    endtask

    task automatic check_table();
        for (int v = 0; v < 4; v++) begin
            check($sformatf("tbl_a_t%0d", vecs[v].t), seen_a[vecs[v].t], vecs[v].a_exp);
            check($sformatf("tbl_b_t%0d", vecs[v].t), seen_b[vecs[v].t], vecs[v].b_exp);
        end
    endtask

    initial begin
        logic [31:0] pat;
        int          len;

        vecs[0] = '{t: 0, a_exp: 16'h0001, b_exp: 16'h0000};
        vecs[1] = '{t: 1, a_exp: 16'h0022, b_exp: 16'h0012};
        vecs[2] = '{t: 3, a_exp: 16'h4444, b_exp: 16'h3456};
        vecs[3] = '{t: 6, a_exp: 16'h7000, b_exp: 16'h9000};

        // Reset held for 3 cycles, then released: stays idle.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_a_edge", a_edge, 0);
        check("rst_b_edge", b_edge, 0);
        check("rst_edge_valid", edge_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ld_ready", ld_ready, 1);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
            check("post_rst_ready", ld_ready, 1);
        end

        // Directed matrix, back-to-back beats.
        set_directed();
        load(32'hF, 4, 0);
        expect_stream(1'b0, 0);
        check_table();
        expect_done_idle();

        // Same matrix with ld_valid pattern 1,0,0,1,1,0,1.
        load(32'b1011001, 7, 0);
        expect_stream(1'b0, 0);
        check_table();
        expect_done_idle();

        // Reset at STREAM t=3, then a fresh load streams from t=0.
        rand_pair(0);
        load(32'hF, 4, 0);
        for (int t = 0; t < 4; t++) begin
            check("pre_rst_a", a_edge, exp_a(t));
            check("pre_rst_b", b_edge, exp_b(t));
            if (t < 3) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_a_edge", a_edge, 0);
        check("midrst_b_edge", b_edge, 0);
        check("midrst_edge_valid", edge_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_ld_ready", ld_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_ready", ld_ready, 1);
        check("after_rst_busy", busy, 0);
        rand_pair(0);
        load(32'hF, 4, 0);
        expect_stream(1'b0, 0);
        expect_done_idle();

        // Random matrices with random load gaps.
        repeat (6) begin
            rand_pair(0);
            pat = '0;
            len = 0;
            for (int b = 0; b < N; b++) begin
                len += $urandom_range(0, 2);
                pat[len] = 1'b1;
                len++;
            end
            load(pat, len, 0);
            expect_stream(1'b0, 0);
            expect_done_idle();
        end

`ifdef SA_FEEDER_DOUBLE_BUF_EN
        // Next pair loads during STREAM; its t=0 coincides with the done pulse.
        rand_pair(0);
        rand_pair(1);
        load(32'hF, 4, 0);
        expect_stream(1'b0, N);
        promote();
        expect_stream(1'b1, 0);
        expect_done_idle();

        // Shadow only half loaded at end of FLUSH: idle until beats 3 and 4.
        rand_pair(0);
        rand_pair(1);
        load(32'hF, 4, 0);
        expect_stream(1'b0, 2);
        expect_done_idle();
        repeat (3) begin
            @(negedge clk);
            check("partial_no_stream", edge_valid, 0);
            check("partial_not_busy", busy, 0);
        end
        promote();
        load(32'b11, 2, 2);
        expect_stream(1'b0, 0);
        expect_done_idle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
